// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    SHIFT,
    CHECK,
    DONE
  } loader_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/config_crc16_serial.sv
// Bit-serial CRC-16-CCITT register, MSB-first, no reflection, no final xor.
module config_crc16_serial
  import config_loader_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic        init,
  input  logic        enable,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;
  logic [15:0] crc_next;
  logic        feedback;

  assign feedback    = crc_reg[15] ^ din;
  assign crc_next[0] = feedback & CRC16_POLY[0];

  generate
    for (genvar gi = 1; gi < 16; gi++) begin : g_crc_bit
      assign crc_next[gi] = crc_reg[gi-1] ^ (feedback & CRC16_POLY[gi]);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!nreset || init) begin
      crc_reg <= CRC16_INIT;
    end else if (enable) begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/config_chain_loader.sv
// Clears the tile configuration chain, then serialises CHAIN_LENGTH bitstream bits into it.
// Define CONFIG_CHAIN_LOADER_CRC_EN to add a trailing CRC-16 check word and the error flag.
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 1152,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int REM_W = $clog2(CHAIN_LENGTH + 1);
  localparam int IN_W  = $clog2(WORD_WIDTH + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  localparam logic [REM_W-1:0] CHAIN_BITS = REM_W'(CHAIN_LENGTH);
  localparam logic [REM_W-1:0] REM_ONE    = REM_W'(1);
  localparam logic [IN_W-1:0]  WORD_BITS  = IN_W'(WORD_WIDTH);
  localparam logic [IN_W-1:0]  IN_ONE     = IN_W'(1);
  localparam logic [CLR_W-1:0] CLR_LAST   = CLR_W'(CLEAR_CYCLES - 1);

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  localparam loader_state_e AFTER_LOAD = CHECK;
`else
  localparam loader_state_e AFTER_LOAD = DONE;
`endif

  loader_state_e         state_reg, state_next;
  logic [REM_W-1:0]      remaining_reg, remaining_next;
  logic [IN_W-1:0]       inword_reg, inword_next;
  logic [CLR_W-1:0]      clear_cnt_reg, clear_cnt_next;
  logic [WORD_WIDTH-1:0] shift_reg, shift_next;

  logic word_ready_reg, word_ready_next;
  logic config_in_reg, config_in_next;
  logic config_enable_reg, config_enable_next;
  logic config_nreset_reg, config_nreset_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic accept;

  // word_ready_reg is high exactly in FETCH/CHECK, so it doubles as the state qualifier
  assign accept = word_valid & word_ready_reg;

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  logic        error_reg, error_next;
  logic [15:0] crc_value;
  logic [15:0] expected_crc;

  assign expected_crc = 16'(word_data);

  config_crc16_serial u_crc (
    .clock  (clock),
    .nreset (nreset),
    .init   (state_reg == CLEAR),
    .enable (config_enable_reg),
    .din    (config_in_reg),
    .crc    (crc_value)
  );

  always_ff @(posedge clock) begin
    if (!nreset) begin
      error_reg <= 1'b0;
    end else begin
      error_reg <= error_next;
    end
  end

  always_comb begin
    error_next = error_reg;
    if ((state_reg == IDLE || state_reg == DONE) && start) begin
      error_next = 1'b0;
    end else if (state_reg == CHECK && accept) begin
      error_next = (crc_value != expected_crc);
    end
  end

  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_reg         <= IDLE;
      remaining_reg     <= '0;
      inword_reg        <= '0;
      clear_cnt_reg     <= '0;
      shift_reg         <= '0;
      word_ready_reg    <= 1'b0;
      config_in_reg     <= 1'b0;
      config_enable_reg <= 1'b0;
      config_nreset_reg <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      remaining_reg     <= remaining_next;
      inword_reg        <= inword_next;
      clear_cnt_reg     <= clear_cnt_next;
      shift_reg         <= shift_next;
      word_ready_reg    <= word_ready_next;
      config_in_reg     <= config_in_next;
      config_enable_reg <= config_enable_next;
      config_nreset_reg <= config_nreset_next;
      busy_reg          <= busy_next;
      done_reg          <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    inword_next    = inword_reg;
    clear_cnt_next = clear_cnt_reg;
    shift_next     = shift_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next     = CLEAR;
          clear_cnt_next = CLR_LAST;
        end
      end
      CLEAR: begin
        remaining_next = CHAIN_BITS;
        if (clear_cnt_reg == '0) begin
          state_next = FETCH;
        end else begin
          clear_cnt_next = clear_cnt_reg - 1'b1;
        end
      end
      FETCH: begin
        if (accept) begin
          shift_next = word_data;
          // the final partial word only contributes its top `remaining` bits
          if (32'(remaining_reg) < WORD_WIDTH) begin
            inword_next = IN_W'(remaining_reg);
          end else begin
            inword_next = WORD_BITS;
          end
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_next     = {shift_reg[WORD_WIDTH-2:0], 1'b0};
        remaining_next = remaining_reg - 1'b1;
        inword_next    = inword_reg - 1'b1;
        if (inword_reg == IN_ONE) begin
          state_next = (remaining_reg == REM_ONE) ? AFTER_LOAD : FETCH;
        end
      end
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
      CHECK: begin
        if (accept) begin
          state_next = DONE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it cycle-for-cycle
  always_comb begin
    word_ready_next    = (state_next == FETCH) || (state_next == CHECK);
    config_enable_next = (state_next == SHIFT);
    config_in_next     = (state_next == SHIFT) && shift_next[WORD_WIDTH-1];
    config_nreset_next = (state_next != CLEAR);
    busy_next          = (state_next != IDLE) && (state_next != DONE);
    done_next          = (state_next == DONE);
  end

  assign word_ready    = word_ready_reg;
  assign config_in     = config_in_reg;
  assign config_enable = config_enable_reg;
  assign config_nreset = config_nreset_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a 36-bit chain and 32-bit words.
// Covers CONFIG_CHAIN_LOADER_CRC_EN builds too when the macro is defined.
module tb_config_chain_loader;

  localparam int WW = 32;
  localparam int CL = 36;
  localparam int CC = 2;

  logic          clock;
  logic          nreset;
  logic          start;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          config_in;
  logic          config_enable;
  logic          config_nreset;
  logic          busy;
  logic          done;
  logic          error;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          en_count = 0;
  int          nrst_low_count = 0;
  int          accept_count = 0;
  logic [63:0] stream = '0;

  config_chain_loader #(
    .WORD_WIDTH   (WW),
    .CHAIN_LENGTH (CL),
    .CLEAR_CYCLES (CC)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .start         (start),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .config_in     (config_in),
    .config_enable (config_enable),
    .config_nreset (config_nreset),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Chain-side observer: collects every enabled bit and handshake
  always @(negedge clock) begin
    if (config_enable) begin
      en_count = en_count + 1;
      stream   = {stream[62:0], config_in};
    end
    if (nreset && !config_nreset) nrst_low_count = nrst_low_count + 1;
    if (word_ready && word_valid) accept_count = accept_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] crc_model(input logic [35:0] bits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 35; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input string tag);
    bit got;
    got        = 1'b0;
    word_data  = w;
    word_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (word_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_accept_timeout"}, 64'(got), 64'd1);
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (word_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_ready_timeout"}, 64'(got), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_done_timeout"}, 64'(got), 64'd1);
  endtask

  task automatic run_load(input string tag, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                          input logic [35:0] exp_bits, input int stall, input bit mid_start,
                          input logic [15:0] crc_flip);
    int e0, n0, a0, es;
    int exp_accepts;
    e0 = en_count;
    n0 = nrst_low_count;
    a0 = accept_count;
    exp_accepts = 2;
    pulse_start();
    send_word(w0, tag);
    if (mid_start) begin
      repeat (3) tick();
      pulse_start();
    end
    if (stall > 0) begin
      wait_ready(tag);
      es = en_count;
      repeat (stall) tick();
      check({tag, "_stall_enables"}, 64'(en_count - es), 64'd0);
    end
    send_word(w1, tag);
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    send_word(32'(crc_model(exp_bits) ^ crc_flip), {tag, "_crc"});
    exp_accepts = 3;
`endif
    wait_done(tag);
    tick();
    check({tag, "_enables"}, 64'(en_count - e0), 64'(CL));
    check({tag, "_clear_cycles"}, 64'(nrst_low_count - n0), 64'(CC));
    check({tag, "_accepts"}, 64'(accept_count - a0), 64'(exp_accepts));
    check({tag, "_stream"}, 64'(stream[35:0]), 64'(exp_bits));
    check({tag, "_done_busy"}, {62'd0, done, busy}, 64'b10);
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    check({tag, "_error"}, 64'(error), 64'(crc_flip != 16'h0));
`else
    check({tag, "_error"}, 64'(error), 64'd0);
`endif
    $display("load %s: enables=%0d stream=%09h done=%0b error=%0b",
             tag, en_count - e0, stream[35:0], done, error);
  endtask

  initial begin
    int e0;
    nreset     = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;

    repeat (3) tick();
    check("reset_outputs",
          {57'd0, word_ready, config_in, config_enable, config_nreset, busy, done, error}, 64'd0);
    nreset = 1'b1;
    tick();
    check("reset_release", {62'd0, config_nreset, busy}, 64'b10);
    $display("reset: config_nreset=%0b busy=%0b", config_nreset, busy);

    run_load("basic", 32'hA5A5_0F0F, 32'hC000_0000, 36'hA5A50F0FC, 0, 1'b0, 16'h0000);
    run_load("stall_ignore", 32'h1234_5678, 32'hF000_0000, 36'h12345678F, 5, 1'b1, 16'h0000);
    run_load("restart", 32'hFFFF_0000, 32'h3ABC_DEF1, 36'hFFFF00003, 0, 1'b0, 16'h0000);

    // Abort a load after ten shifted bits
    e0 = en_count;
    pulse_start();
    send_word(32'hDEAD_BEEF, "abort");
    repeat (9) tick();
    nreset = 1'b0;
    tick();
    check("abort_enables", 64'(en_count - e0), 64'd10);
    check("abort_outputs", {60'd0, config_nreset, config_enable, busy, word_ready}, 64'd0);
    $display("abort: enables=%0d config_nreset=%0b", en_count - e0, config_nreset);
    tick();
    nreset = 1'b1;
    tick();

    run_load("after_abort", 32'hA5A5_0F0F, 32'hC000_0000, 36'hA5A50F0FC, 0, 1'b0, 16'h0000);
    run_load("crc_flip", 32'h1357_9BDF, 32'hA000_0000, 36'h13579BDFA, 0, 1'b0, 16'h0001);
    run_load("crc_clear", 32'h0F0F_A5A5, 32'h9000_0000, 36'h0F0FA5A59, 0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
